// File: rtl/imm_pack.sv
// imm_pack: scatters a signed immediate into the I/S/B/J fields of an
// instruction template. It is the inverse of the core's immediate extender.
// The datapath is a two-stage valid/ready pipeline. Stage A registers the
// request. Stage B registers the packed instruction and its range flag.
// A saturating counter tracks consumed results that were flagged.
module imm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       imm_src_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      base_instr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      instr_o,
    output logic             range_err_o,
    output logic [CNT_W-1:0] err_count_o
);

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } immFmt_e;

    // Stage A: the accepted request.
    logic        validA_q;
    immFmt_e     srcA_q;
    logic [31:0] immA_q;
    logic [31:0] baseA_q;

    // Stage B: the packed result.
    logic        validB_q;
    logic [31:0] instrB_q;
    logic        errB_q;

    // Saturating range-error counter.
    logic [CNT_W-1:0] errCount_q;
    logic [CNT_W-1:0] errCount_d;

    // Combinational pack and range check of the stage A contents.
    logic [31:0] packed_d;
    logic        rangeErr_d;

    logic advB;

    // Stage B can take a new value when it is empty or being drained this cycle.
    assign advB       = !validB_q || out_ready_i;
    assign in_ready_o = !validA_q || advB;

    assign out_valid_o = validB_q;
    assign instr_o     = instrB_q;
    assign range_err_o = errB_q;
    assign err_count_o = errCount_q;

    // Stage A register: capture a new request whenever the slot is free or moving on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            validA_q <= 1'b0;
            srcA_q   <= FMT_I;
            immA_q   <= 32'd0;
            baseA_q  <= 32'd0;
        end else if (in_ready_o) begin
            validA_q <= in_valid_i;
            if (in_valid_i) begin
                srcA_q  <= immFmt_e'(imm_src_i);
                immA_q  <= imm_i;
                baseA_q <= base_instr_i;
            end
        end
    end

    // Scatter the immediate into the format's fields. Flag values the format
    // cannot represent, such as a truncated high part or an odd branch or jump offset.
    always_comb begin
        packed_d   = baseA_q;
        rangeErr_d = 1'b0;
        unique case (srcA_q)
            FMT_I: begin
                packed_d[31:20] = immA_q[11:0];
                rangeErr_d      = !((&immA_q[31:11]) || !(|immA_q[31:11]));
            end
            FMT_S: begin
                packed_d[31:25] = immA_q[11:5];
                packed_d[11:7]  = immA_q[4:0];
                rangeErr_d      = !((&immA_q[31:11]) || !(|immA_q[31:11]));
            end
            FMT_B: begin
                packed_d[31]    = immA_q[12];
                packed_d[30:25] = immA_q[10:5];
                packed_d[11:8]  = immA_q[4:1];
                packed_d[7]     = immA_q[11];
                rangeErr_d      = immA_q[0] || !((&immA_q[31:12]) || !(|immA_q[31:12]));
            end
            FMT_J: begin
                packed_d[31]    = immA_q[20];
                packed_d[30:21] = immA_q[10:1];
                packed_d[20]    = immA_q[11];
                packed_d[19:12] = immA_q[19:12];
                rangeErr_d      = immA_q[0] || !((&immA_q[31:20]) || !(|immA_q[31:20]));
            end
            default: begin
                packed_d   = baseA_q;
                rangeErr_d = 1'b0;
            end
        endcase
    end

    // Stage B register: load from stage A when allowed, otherwise hold the result steady.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            validB_q <= 1'b0;
            instrB_q <= 32'd0;
            errB_q   <= 1'b0;
        end else if (advB) begin
            validB_q <= validA_q;
            instrB_q <= packed_d;
            errB_q   <= validA_q && rangeErr_d;
        end
    end

    // Count flagged results only at the moment they are consumed. Stop at all-ones.
    always_comb begin
        errCount_d = errCount_q;
        if (validB_q && out_ready_i && errB_q && !(&errCount_q)) begin
            errCount_d = errCount_q + CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            errCount_q <= '0;
        end else begin
            errCount_q <= errCount_d;
        end
    end

endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Immediate packer: the inverse of the core's immediate extender. Takes a 32-bit signed immediate, a format select and a base instruction, and scatters the immediate into the I/S/B/J bit fields of instr[31:7].
- Feeds the debug program buffer and trap-stub generator, which synthesise jal/branch/load/store instructions at run time.
- Two-stage valid/ready pipeline.
- Flags immediates that the selected format cannot represent, and counts those flagged results.

Parameters:
- CNT_W, 16, width of the saturating range-error counter (>=2).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o
- imm_src_i  in  2  format: 00 I, 01 S, 10 B, 11 J
- imm_i  in  32  signed immediate / byte offset
- base_instr_i  in  32  instruction template (opcode, rd, rs1, rs2, funct bits)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when out_valid_o && out_ready_i
- instr_o  out  32  packed instruction
- range_err_o  out  1  imm_i not representable in the selected format (qualified by out_valid_o)
- err_count_o  out  CNT_W  saturating count of consumed results with range_err_o=1

Behaviour:
- Reset (rst_ni low, asynchronous): out_valid_o=0, instr_o=0, range_err_o=0, err_count_o=0, stage-A valid=0.
  - in_ready_o is 1 in the first cycle after release.
  - Reset mid-transfer drops all in-flight requests.
- Stage A: input register holding imm_src, imm and base, plus valid_a.
- Stage B: output register holding out_valid_o, instr_o and range_err_o.
- Stall rules:
  - adv_b = !out_valid_o || out_ready_i
  - in_ready_o = !valid_a || adv_b (combinational)
  - On adv_b: stage B loads the packed value from stage A, and out_valid_o <= valid_a.
  - When adv_b is 0, stage B holds instr_o and range_err_o stable.
- Latency: a request accepted at edge N shows out_valid_o=1 after edge N+1. Throughput is 1 per cycle when out_ready_i=1.
- A simultaneous accept and consume at the same edge is legal; no bubble is inserted.
- Packing: instr_o starts as base_instr; only the listed field bits are overwritten. instr[6:0] always comes from base.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
  - B: [31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11].
  - J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
- Range check (computed in stage A, registered into stage B):
  - I/S: error if imm[31:11] is not all-equal.
  - B: error if imm[0]=1 or imm[31:12] is not all-equal.
  - J: error if imm[0]=1 or imm[31:20] is not all-equal.
  - On error, instr_o is still packed from the truncated bits; no other side effect.
- Round-trip invariant: when range_err_o=0, sign-extending instr_o with the same format returns exactly imm_i.
- Counter: err_count_o increments by 1 at each edge with out_valid_o && out_ready_i && range_err_o.
  - Saturates at all-ones and never wraps.
  - A stalled erroneous result is counted once, on consumption only.

Test Plan:
- I-format, imm=0xFFFFFFFF, base=0x00000013, out_ready_i=1 -> after 2 edges instr_o=0xFFF00013, range_err_o=0.
- B-format, imm=0x00000800, base=0x00000063 -> instr_o=0x000000E3 (bit7=1), range_err_o=0. Then imm=0x00001000 -> range_err_o=1, err_count_o=1 after consumption.
- J-format, imm=0xFFFFFFFE, base=0x000000EF -> instr_o=0xFFFFF0EF, no error. Then imm=0x00000003 -> range_err_o=1.
- Back-to-back stream of 8 requests with out_ready_i held low for 3 cycles mid-stream -> in_ready_o=0 when both stages are full; instr_o stable while stalled; all 8 results emitted in order with none lost or duplicated.
- CNT_W=2, five consecutive erroneous S-format requests (imm=0x00000800) -> err_count_o goes 1,2,3,3,3; an erroneous result held under stall for 4 cycles increments once.
- Assert rst_ni low asynchronously while both stages are valid -> out_valid_o and err_count_o clear immediately, in_ready_o=1 after release, and no stale output appears afterwards.
